p405s_dsmmu_sprselarb: RTL and testbench
========================================

// Module: p405s_dsMMU_sprSelArb
// PURPOSE
//  Shares the MMU 1-of-32 SPR bit selector between I-side and D-side requesters.
//  The selector extracts one bit each from SPR1 and SPR2 by a 5-bit EA field and drives inverted outputs.
//  This block arbitrates the two lookups, drives the selector EA and registers and re-inverts the result.
//  It also interlocks SPR writes (mtspr) so no lookup samples an SPR that is being updated.
// PARAMETERS
//  D_PRIORITY   1  1: fixed D-side priority with starvation guard; 0: round-robin
//  STARVE_MAX   3  consecutive lost contests after which I-side is forced to win (D_PRIORITY=1); range 1..7
//  WR_HOLD_CYC  2  cycles after an SPR write grant during which no lookup is granted; range 1..7
// PORTS
//  CB            in   1      core clock; all state updates on rising edge
//  coreReset_N   in   1      asynchronous reset, active-low
//  iReq          in   1      I-side lookup request, level, held until iGnt
//  iEa           in   [0:4]  I-side bit index, stable while iReq=1
//  iGnt          out  1      one-cycle grant to I-side
//  iRspVld       out  1      I-side result valid (one cycle)
//  iRsp1/iRsp2   out  1      selected SPR1/SPR2 bit, true polarity
//  dReq/dEa/dGnt/dRspVld/dRsp1/dRsp2   same as I-side, for the D-side
//  sprWrReq      in   1      SPR unit requests to write SPR1/SPR2, level, held until sprWrGnt
//  sprWrGnt      out  1      one-cycle grant; SPR unit writes on the edge that ends this cycle
//  selEa         out  [0:4]  EA driven to the selector
//  selSpr1Out_N  in   1      selector output for SPR1, inverted
//  selSpr2Out_N  in   1      selector output for SPR2, inverted
// BEHAVIOUR
//  Reset (async, coreReset_N=0)
//   - All gnt/RspVld/Rsp outputs = 0; selEa = 5'b0.
//   - State ARB, starvation count 0, round-robin last-winner = I.
//   - An in-flight response is dropped; requesters must re-request.
//  States
//   - ARB: grant logic active.
//   - HOLD: count down WR_HOLD_CYC cycles, then return to ARB.
//  ARB, priority order per cycle
//   1. sprWrReq=1: sprWrGnt=1, no lookup grant; next state HOLD with count = WR_HOLD_CYC.
//   2. Otherwise grant one lookup, combinationally in the same cycle:
//      - Only one requester: it wins.
//      - Both, D_PRIORITY=1: D wins, unless starve count = STARVE_MAX; then I wins and count clears.
//        A D win against a pending iReq increments the count (saturating).
//        Any I grant clears the count.
//      - Both, D_PRIORITY=0: the side that is not last-winner wins; last-winner updates on every grant.
//   - selEa = winner's EA in the grant cycle; otherwise holds its last value.
//  HOLD
//   - No grants of any kind; requests stay pending.
//   - Starve count is not incremented.
//   - After WR_HOLD_CYC cycles, next state ARB.
//  Lookup latency is 1
//   - Selector outputs are captured at the edge ending the grant cycle N.
//   - In cycle N+1: xRspVld=1, xRsp1 = ~selSpr1Out_N, xRsp2 = ~selSpr2Out_N.
//   - xRsp1/xRsp2 hold their value until the next response to that side.
//  Throughput: one lookup per cycle; back-to-back grants to the same side are legal.
//  Deasserting xReq without a grant is legal; nothing is issued for that side.
//  Never: iGnt & dGnt, or any lookup gnt together with sprWrGnt.
// TESTING
//  1. SPR1=32'h8000_0001, SPR2=32'h0; dReq, dEa=0 -> dGnt cycle N, selEa=0; cycle N+1 dRspVld=1, dRsp1=1, dRsp2=0.
//  2. iReq+dReq held, D_PRIORITY=1, STARVE_MAX=3 -> grant order D,D,D,I,D,D,D,I; never both gnt in one cycle.
//  3. D_PRIORITY=0, both held -> D,I,D,I alternation starting with D after reset.
//  4. sprWrReq with dReq pending, WR_HOLD_CYC=2 -> sprWrGnt cycle N; no gnt in N+1,N+2; dGnt in N+3, result reflects new SPR.
//  5. iEa=31, SPR2 bit31=1 -> iRsp2=1 one cycle after iGnt; selEa holds 31 while idle.
//  6. coreReset_N low during an RspVld cycle -> all outputs 0 immediately; after release, first lookup behaves as in scenario 1.

Source files
------------

// File: rtl/p405s_dsmmu_sprselarb_if.sv
// ----------------------------------------------------------------------------
// p405s_dsmmu_sprselarb_if
// Bundles the request/grant/response signals and the shared SPR bit-selector
// connection used by the SPR selector arbiter.
//   slave  : the arbiter (consumes requests and selector outputs, drives grants,
//            responses and the selector EA)
//   master : the surroundings (I-side, D-side, SPR unit and the selector itself)
// Signals:
//   iReq/iEa, dReq/dEa        lookup requests and bit indices (EA bit 0 = MSB)
//   iGnt/dGnt                 one-cycle lookup grants
//   iRspVld/iRsp1/iRsp2       I-side response (true polarity)
//   dRspVld/dRsp1/dRsp2       D-side response (true polarity)
//   sprWrReq/sprWrGnt         SPR write interlock handshake
//   selEa                     EA driven to the shared selector
//   selSpr1Out_N/selSpr2Out_N inverted selector outputs
// ----------------------------------------------------------------------------
interface p405s_dsmmu_sprselarb_if;
  logic       iReq;
  logic [0:4] iEa;
  logic       iGnt;
  logic       iRspVld;
  logic       iRsp1;
  logic       iRsp2;
  logic       dReq;
  logic [0:4] dEa;
  logic       dGnt;
  logic       dRspVld;
  logic       dRsp1;
  logic       dRsp2;
  logic       sprWrReq;
  logic       sprWrGnt;
  logic [0:4] selEa;
  logic       selSpr1Out_N;
  logic       selSpr2Out_N;

  modport slave (
    input  iReq, iEa, dReq, dEa, sprWrReq, selSpr1Out_N, selSpr2Out_N,
    output iGnt, iRspVld, iRsp1, iRsp2, dGnt, dRspVld, dRsp1, dRsp2,
           sprWrGnt, selEa
  );

  modport master (
    output iReq, iEa, dReq, dEa, sprWrReq, selSpr1Out_N, selSpr2Out_N,
    input  iGnt, iRspVld, iRsp1, iRsp2, dGnt, dRspVld, dRsp1, dRsp2,
           sprWrGnt, selEa
  );
endinterface

// File: rtl/p405s_dsmmu_sprselarb.sv
// ----------------------------------------------------------------------------
// p405s_dsmmu_sprselarb
// Arbitrates I-side and D-side lookups of the shared MMU 1-of-32 SPR bit
// selector, drives the selector EA, registers and re-inverts its outputs, and
// interlocks SPR writes so no lookup samples an SPR while it is being updated.
// Ports:
//   CB           core clock, rising edge
//   coreReset_N  asynchronous reset, active-low
//   bus          arbiter side of p405s_dsmmu_sprselarb_if
// Parameters:
//   D_PRIORITY   1: D-side priority with starvation guard, 0: round-robin
//   STARVE_MAX   lost contests after which the I-side is forced to win (1..7)
//   WR_HOLD_CYC  lookup-free cycles following an SPR write grant (1..7)
// ----------------------------------------------------------------------------
module p405s_dsmmu_sprselarb #(
  parameter int D_PRIORITY  = 1,
  parameter int STARVE_MAX  = 3,
  parameter int WR_HOLD_CYC = 2
) (
  input  logic                          CB,
  input  logic                          coreReset_N,
  p405s_dsmmu_sprselarb_if.slave        bus
);

  typedef enum logic {ST_ARB, ST_HOLD} state_t;

  localparam logic [2:0] LP_STARVE_MAX = 3'(STARVE_MAX);
  localparam logic [2:0] LP_HOLD_CYC   = 3'(WR_HOLD_CYC);

  state_t     r_state;
  logic [2:0] r_hold_cnt;
  logic [2:0] r_starve;
  logic       r_last_i;
  logic [0:4] r_selEa;
  logic       r_iRspVld;
  logic       r_iRsp1;
  logic       r_iRsp2;
  logic       r_dRspVld;
  logic       r_dRsp1;
  logic       r_dRsp2;

  logic       w_arb;
  logic       w_wr_gnt;
  logic       w_lookup;
  logic       w_i_forced;
  logic       w_i_wins;
  logic       w_iGnt;
  logic       w_dGnt;
  logic [0:4] w_selEa;

  // Grants are combinational in the request cycle; reset gates them so every
  // grant output is low while coreReset_N is asserted.
  assign w_arb    = (r_state == ST_ARB) && coreReset_N;
  assign w_wr_gnt = w_arb && bus.sprWrReq;
  assign w_lookup = w_arb && !bus.sprWrReq;

  // Contest resolution when both sides request: either the starvation guard
  // (D priority) or alternation away from the last winner (round-robin).
  assign w_i_forced = (D_PRIORITY != 0) ? (r_starve == LP_STARVE_MAX) : !r_last_i;
  assign w_i_wins   = bus.iReq && (!bus.dReq || w_i_forced);
  assign w_iGnt     = w_lookup && w_i_wins;
  assign w_dGnt     = w_lookup && bus.dReq && !w_i_wins;

  // The selector must see the winner's EA within the grant cycle so its output
  // can be captured at the edge that ends it.
  assign w_selEa = w_iGnt ? bus.iEa : (w_dGnt ? bus.dEa : r_selEa);

  assign bus.iGnt     = w_iGnt;
  assign bus.dGnt     = w_dGnt;
  assign bus.sprWrGnt = w_wr_gnt;
  assign bus.selEa    = w_selEa;
  assign bus.iRspVld  = r_iRspVld;
  assign bus.iRsp1    = r_iRsp1;
  assign bus.iRsp2    = r_iRsp2;
  assign bus.dRspVld  = r_dRspVld;
  assign bus.dRsp1    = r_dRsp1;
  assign bus.dRsp2    = r_dRsp2;

  always_ff @(posedge CB or negedge coreReset_N) begin
    if (!coreReset_N) begin
      r_state    <= ST_ARB;
      r_hold_cnt <= 3'd0;
      r_starve   <= 3'd0;
      r_last_i   <= 1'b1;
      r_selEa    <= 5'd0;
      r_iRspVld  <= 1'b0;
      r_iRsp1    <= 1'b0;
      r_iRsp2    <= 1'b0;
      r_dRspVld  <= 1'b0;
      r_dRsp1    <= 1'b0;
      r_dRsp2    <= 1'b0;
    end else begin
      case (r_state)
        ST_ARB: begin
          if (w_wr_gnt) begin
            r_state    <= ST_HOLD;
            r_hold_cnt <= LP_HOLD_CYC;
          end
        end
        ST_HOLD: begin
          // Last hold cycle returns to arbitration for the next cycle.
          if (r_hold_cnt <= 3'd1) begin
            r_state    <= ST_ARB;
            r_hold_cnt <= 3'd0;
          end else begin
            r_hold_cnt <= r_hold_cnt - 3'd1;
          end
        end
        default: r_state <= ST_ARB;
      endcase

      // Only a D win against a waiting I-side counts as a lost contest.
      if (w_iGnt) begin
        r_starve <= 3'd0;
      end else if (w_dGnt && bus.iReq && (r_starve != LP_STARVE_MAX)) begin
        r_starve <= r_starve + 3'd1;
      end

      if (w_iGnt) begin
        r_last_i <= 1'b1;
      end else if (w_dGnt) begin
        r_last_i <= 1'b0;
      end

      if (w_iGnt || w_dGnt) begin
        r_selEa <= w_selEa;
      end

      // Response stage: capture and re-invert selector outputs of the grant cycle.
      r_iRspVld <= w_iGnt;
      r_dRspVld <= w_dGnt;
      if (w_iGnt) begin
        r_iRsp1 <= !bus.selSpr1Out_N;
        r_iRsp2 <= !bus.selSpr2Out_N;
      end
      if (w_dGnt) begin
        r_dRsp1 <= !bus.selSpr1Out_N;
        r_dRsp2 <= !bus.selSpr2Out_N;
      end
    end
  end

endmodule

// File: tb/tb_p405s_dsmmu_sprselarb.sv
// ----------------------------------------------------------------------------
// tb_p405s_dsmmu_sprselarb
// Two arbiters side by side: dut0 with D-side priority, dut1 round-robin.
// Each has its own requesters, SPR pair and selector model. A reference model
// predicts grants, selector EA and responses every cycle; directed scenarios
// add hand-computed expectations, followed by a randomized phase.
// ----------------------------------------------------------------------------
module tb_p405s_dsmmu_sprselarb;
  localparam int STARVE_MAX  = 3;
  localparam int WR_HOLD_CYC = 2;

  logic CB = 1'b0;
  logic rst_n = 1'b0;
  always #5 CB = ~CB;

  logic       iReq[2], dReq[2], wrReq[2];
  logic [4:0] iEa[2], dEa[2];
  logic [0:31] spr1[2], spr2[2], nxt1[2], nxt2[2];
  bit         wpend[2];

  logic       o_ig[2], o_dg[2], o_wg[2], o_iv[2], o_dv[2];
  logic       o_i1[2], o_i2[2], o_d1[2], o_d2[2];
  logic [4:0] o_sel[2];

  p405s_dsmmu_sprselarb_if bus0();
  p405s_dsmmu_sprselarb_if bus1();

  assign bus0.iReq = iReq[0];  assign bus0.iEa = iEa[0];
  assign bus0.dReq = dReq[0];  assign bus0.dEa = dEa[0];
  assign bus0.sprWrReq = wrReq[0];
  assign bus0.selSpr1Out_N = ~spr1[0][bus0.selEa];
  assign bus0.selSpr2Out_N = ~spr2[0][bus0.selEa];
  assign bus1.iReq = iReq[1];  assign bus1.iEa = iEa[1];
  assign bus1.dReq = dReq[1];  assign bus1.dEa = dEa[1];
  assign bus1.sprWrReq = wrReq[1];
  assign bus1.selSpr1Out_N = ~spr1[1][bus1.selEa];
  assign bus1.selSpr2Out_N = ~spr2[1][bus1.selEa];

  assign o_ig[0] = bus0.iGnt;    assign o_ig[1] = bus1.iGnt;
  assign o_dg[0] = bus0.dGnt;    assign o_dg[1] = bus1.dGnt;
  assign o_wg[0] = bus0.sprWrGnt; assign o_wg[1] = bus1.sprWrGnt;
  assign o_iv[0] = bus0.iRspVld; assign o_iv[1] = bus1.iRspVld;
  assign o_dv[0] = bus0.dRspVld; assign o_dv[1] = bus1.dRspVld;
  assign o_i1[0] = bus0.iRsp1;   assign o_i1[1] = bus1.iRsp1;
  assign o_i2[0] = bus0.iRsp2;   assign o_i2[1] = bus1.iRsp2;
  assign o_d1[0] = bus0.dRsp1;   assign o_d1[1] = bus1.dRsp1;
  assign o_d2[0] = bus0.dRsp2;   assign o_d2[1] = bus1.dRsp2;
  assign o_sel[0] = bus0.selEa;  assign o_sel[1] = bus1.selEa;

  p405s_dsmmu_sprselarb #(.D_PRIORITY(1), .STARVE_MAX(STARVE_MAX), .WR_HOLD_CYC(WR_HOLD_CYC))
    dut0 (.CB(CB), .coreReset_N(rst_n), .bus(bus0.slave));
  p405s_dsmmu_sprselarb #(.D_PRIORITY(0), .STARVE_MAX(STARVE_MAX), .WR_HOLD_CYC(WR_HOLD_CYC))
    dut1 (.CB(CB), .coreReset_N(rst_n), .bus(bus1.slave));

  // Reference model state
  int m_hold[2], m_starve[2], m_sel[2];
  bit m_lastI[2];
  bit m_iv[2], m_i1[2], m_i2[2], m_dv[2], m_d1[2], m_d2[2];

  // Values sampled in the most recent checked cycle
  bit s_ig[2], s_dg[2], s_wg[2], s_iv[2], s_dv[2], s_i1[2], s_i2[2], s_d1[2], s_d2[2];
  int s_sel[2];

  int errs = 0;
  int chks = 0;

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    chks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s dut%0d @%0t: got %0h expected %0h", nm, k, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_hold[k] = 0; m_starve[k] = 0; m_sel[k] = 0; m_lastI[k] = 1'b1;
      m_iv[k] = 0; m_i1[k] = 0; m_i2[k] = 0; m_dv[k] = 0; m_d1[k] = 0; m_d2[k] = 0;
      wpend[k] = 0;
    end
  endtask

  // Checks one cycle whose inputs are already applied, then moves to the next
  // falling edge where any granted SPR write has taken effect.
  task automatic cyc();
    bit ig, dg, wg;
    int esel;
    #1;
    for (int k = 0; k < 2; k++) begin
      ig = 0; dg = 0; wg = 0;
      if (m_hold[k] == 0) begin
        if (wrReq[k]) wg = 1;
        else if (iReq[k] && dReq[k]) begin
          if (k == 0) begin
            if (m_starve[k] == STARVE_MAX) ig = 1; else dg = 1;
          end else begin
            if (m_lastI[k]) dg = 1; else ig = 1;
          end
        end else if (iReq[k]) ig = 1;
        else if (dReq[k]) dg = 1;
      end
      esel = ig ? int'(iEa[k]) : (dg ? int'(dEa[k]) : m_sel[k]);

      s_ig[k] = o_ig[k]; s_dg[k] = o_dg[k]; s_wg[k] = o_wg[k];
      s_iv[k] = o_iv[k]; s_dv[k] = o_dv[k]; s_sel[k] = int'(o_sel[k]);
      s_i1[k] = o_i1[k]; s_i2[k] = o_i2[k]; s_d1[k] = o_d1[k]; s_d2[k] = o_d2[k];

      chk("iGnt", k, o_ig[k], ig);
      chk("dGnt", k, o_dg[k], dg);
      chk("sprWrGnt", k, o_wg[k], wg);
      chk("selEa", k, o_sel[k], esel);
      chk("iRspVld", k, o_iv[k], m_iv[k]);
      chk("dRspVld", k, o_dv[k], m_dv[k]);
      chk("iRsp1", k, o_i1[k], m_i1[k]);
      chk("iRsp2", k, o_i2[k], m_i2[k]);
      chk("dRsp1", k, o_d1[k], m_d1[k]);
      chk("dRsp2", k, o_d2[k], m_d2[k]);

      m_iv[k] = ig; m_dv[k] = dg;
      if (ig) begin m_i1[k] = spr1[k][iEa[k]]; m_i2[k] = spr2[k][iEa[k]]; end
      if (dg) begin m_d1[k] = spr1[k][dEa[k]]; m_d2[k] = spr2[k][dEa[k]]; end
      if (wg) m_hold[k] = WR_HOLD_CYC;
      else if (m_hold[k] > 0) m_hold[k]--;
      if (ig) m_starve[k] = 0;
      else if (dg && iReq[k] && m_starve[k] < STARVE_MAX) m_starve[k]++;
      if (ig) m_lastI[k] = 1'b1;
      else if (dg) m_lastI[k] = 1'b0;
      m_sel[k] = esel;
      if (wg) wpend[k] = 1;
    end
    @(posedge CB);
    @(negedge CB);
    for (int k = 0; k < 2; k++) begin
      if (wpend[k]) begin
        spr1[k] = nxt1[k]; spr2[k] = nxt2[k]; wpend[k] = 0;
      end
    end
  endtask

  task automatic clear_inputs();
    for (int k = 0; k < 2; k++) begin
      iReq[k] = 0; dReq[k] = 0; wrReq[k] = 0;
    end
  endtask

  // Asserts reset wherever the bench currently is in the cycle and checks that
  // every output drops at once, then releases on a falling edge.
  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("rst_iGnt", k, o_ig[k], 0);
      chk("rst_dGnt", k, o_dg[k], 0);
      chk("rst_wrGnt", k, o_wg[k], 0);
      chk("rst_iRspVld", k, o_iv[k], 0);
      chk("rst_dRspVld", k, o_dv[k], 0);
      chk("rst_rsp", k, {o_i1[k], o_i2[k], o_d1[k], o_d2[k]}, 0);
      chk("rst_selEa", k, o_sel[k], 0);
    end
    model_reset();
    @(negedge CB);
    @(negedge CB);
    rst_n = 1'b1;
  endtask

  task automatic scen1();
    for (int k = 0; k < 2; k++) begin
      spr1[k] = 32'h8000_0001; spr2[k] = 32'h0; dReq[k] = 1; dEa[k] = 5'd0;
    end
    cyc();
    for (int k = 0; k < 2; k++) begin
      chk("s1_dGnt", k, s_dg[k], 1);
      chk("s1_selEa", k, s_sel[k], 0);
      dReq[k] = 0;
    end
    cyc();
    for (int k = 0; k < 2; k++) begin
      chk("s1_dRspVld", k, s_dv[k], 1);
      chk("s1_dRsp1", k, s_d1[k], 1);
      chk("s1_dRsp2", k, s_d2[k], 0);
    end
  endtask

  initial begin
    string ord0, ord1;
    byte   got;
    clear_inputs();
    for (int k = 0; k < 2; k++) begin
      iEa[k] = 0; dEa[k] = 0; spr1[k] = 0; spr2[k] = 0; nxt1[k] = 0; nxt2[k] = 0;
    end
    model_reset();
    do_reset();

    // Scenario 1: basic D lookup
    scen1();

    // Scenarios 2/3: both sides held continuously
    do_reset();
    ord0 = "DDDIDDDI";
    ord1 = "DIDIDIDI";
    for (int k = 0; k < 2; k++) begin
      iReq[k] = 1; dReq[k] = 1; iEa[k] = 5'd3; dEa[k] = 5'd7;
    end
    for (int c = 0; c < 8; c++) begin
      cyc();
      got = s_ig[0] ? "I" : (s_dg[0] ? "D" : "-");
      chk("s2_order", 0, got, ord0[c]);
      got = s_ig[1] ? "I" : (s_dg[1] ? "D" : "-");
      chk("s3_order", 1, got, ord1[c]);
      for (int k = 0; k < 2; k++) chk("excl_gnt", k, s_ig[k] & s_dg[k], 0);
    end
    clear_inputs();
    cyc();

    // Scenario 4: SPR write interlock with a pending D lookup
    for (int k = 0; k < 2; k++) begin
      spr1[k] = 32'h0; spr2[k] = 32'h0;
      nxt1[k] = 32'hFFFF_FFFF; nxt2[k] = 32'h0;
      wrReq[k] = 1; dReq[k] = 1; dEa[k] = 5'd5;
    end
    cyc();
    for (int k = 0; k < 2; k++) begin
      chk("s4_wrGnt", k, s_wg[k], 1);
      chk("s4_noGntN", k, s_dg[k], 0);
      wrReq[k] = 0;
    end
    cyc();
    for (int k = 0; k < 2; k++) chk("s4_noGntN1", k, s_dg[k], 0);
    cyc();
    for (int k = 0; k < 2; k++) chk("s4_noGntN2", k, s_dg[k], 0);
    cyc();
    for (int k = 0; k < 2; k++) begin
      chk("s4_dGntN3", k, s_dg[k], 1);
      dReq[k] = 0;
    end
    cyc();
    for (int k = 0; k < 2; k++) chk("s4_newSpr", k, s_d1[k], 1);

    // Scenario 5: EA 31, selEa holds while idle
    for (int k = 0; k < 2; k++) begin
      spr2[k] = 32'h0000_0001; iReq[k] = 1; iEa[k] = 5'd31;
    end
    cyc();
    for (int k = 0; k < 2; k++) begin
      chk("s5_iGnt", k, s_ig[k], 1);
      chk("s5_selEa", k, s_sel[k], 31);
      iReq[k] = 0;
    end
    cyc();
    for (int k = 0; k < 2; k++) chk("s5_iRsp2", k, s_i2[k], 1);
    cyc();
    cyc();
    for (int k = 0; k < 2; k++) begin
      chk("s5_selHold", k, s_sel[k], 31);
      chk("s5_rspHold", k, s_i2[k], 1);
    end

    // Scenario 6: reset during a response cycle
    for (int k = 0; k < 2; k++) begin
      spr1[k] = 32'h8000_0001; dReq[k] = 1; dEa[k] = 5'd0;
    end
    cyc();
    clear_inputs();
    #1;
    for (int k = 0; k < 2; k++) chk("s6_vldBefore", k, k == 0 ? o_dv[0] : o_dv[1], 1);
    #1;
    do_reset();
    scen1();

    // Randomized phase
    do_reset();
    for (int k = 0; k < 2; k++) begin
      s_ig[k] = 0; s_dg[k] = 0; s_wg[k] = 0;
      spr1[k] = $urandom; spr2[k] = $urandom;
    end
    for (int c = 0; c < 4000; c++) begin
      for (int k = 0; k < 2; k++) begin
        if (iReq[k] && s_ig[k]) iReq[k] = 0;
        else if (iReq[k] && $urandom_range(0, 15) == 0) iReq[k] = 0;
        else if (!iReq[k] && $urandom_range(0, 2) == 0) begin
          iReq[k] = 1; iEa[k] = 5'($urandom);
        end
        if (dReq[k] && s_dg[k]) dReq[k] = 0;
        else if (dReq[k] && $urandom_range(0, 15) == 0) dReq[k] = 0;
        else if (!dReq[k] && $urandom_range(0, 1) == 0) begin
          dReq[k] = 1; dEa[k] = 5'($urandom);
        end
        if (wrReq[k] && s_wg[k]) wrReq[k] = 0;
        else if (!wrReq[k] && $urandom_range(0, 19) == 0) begin
          wrReq[k] = 1; nxt1[k] = $urandom; nxt2[k] = $urandom;
        end
      end
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", errs, chks);
    $finish;
  end
endmodule
